// File: rtl/sync_barrier_controller_pkg.sv
// Shared state encodings, error codes, default widths and error-update helper for the barrier controller.
package sync_barrier_controller_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int unsigned ERR_W = 2;
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_NONMEMBER = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

  localparam int unsigned DEF_NUM_TILES = 4;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_TIMEOUT_W = 16;

  // Sticky first-error code: a new error only lands on an empty (or just-cleared) code.
  function automatic logic [ERR_W-1:0] err_code_next(input logic [ERR_W-1:0] cur,
                                                     input logic             set,
                                                     input logic             clr,
                                                     input logic [ERR_W-1:0] code_new);
    logic [ERR_W-1:0] res;
    res = cur;
    if (set) begin
      if (clr || (cur == ERR_NONE)) res = code_new;
    end else if (clr) begin
      res = ERR_NONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_arrival_tracker.sv
// Per-tile armed/arrived bookkeeping; a held request counts once and re-arms only after it drops.
module sync_arrival_tracker
  import sync_barrier_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic request,
  input  logic mask,
  input  logic arm_en,
  input  logic rel,
  output logic arrived,
  output logic new_arrival_c
);

  logic armed_q, armed_d;
  logic arrived_q, arrived_d;

  always_comb begin
    armed_d       = armed_q;
    arrived_d     = arrived_q;
    new_arrival_c = request & armed_q & mask & arm_en & ~arrived_q;
    if (rel) begin
      armed_d   = 1'b0;
      arrived_d = 1'b0;
    end else begin
      if (!request) armed_d = 1'b1;
      if (new_arrival_c) arrived_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b1;
      arrived_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      arrived_q <= arrived_d;
    end
  end

  assign arrived = arrived_q;

endmodule

// File: rtl/sync_barrier_controller.sv
// Global barrier arbiter: collects per-tile sync requests and releases all participants together.
// Optional SYNC_BARRIER_TIMEOUT_EN adds cfg_timeout and a forced partial release from COLLECT.
module sync_barrier_controller
  import sync_barrier_controller_pkg::*;
#(
  parameter int unsigned NUM_TILES = DEF_NUM_TILES,
  parameter int unsigned CNT_W     = DEF_CNT_W
`ifdef SYNC_BARRIER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_TILES-1:0] cfg_mask,
  input  logic                 cfg_mask_we,
`ifdef SYNC_BARRIER_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
`endif
  input  logic                 err_clr,
  input  logic [NUM_TILES-1:0] sync_request,
  output logic [NUM_TILES-1:0] sync_grant,
  output logic                 global_sync,
  output logic [NUM_TILES-1:0] arrived,
  output logic                 busy,
  output logic [CNT_W-1:0]     barrier_count,
  output logic                 error,
  output logic [ERR_W-1:0]     err_code
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [NUM_TILES-1:0] mask_q, mask_d;
  logic [NUM_TILES-1:0] pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;
  logic [NUM_TILES-1:0] sync_grant_q, sync_grant_d;
  logic                 global_sync_q, global_sync_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     barrier_count_q, barrier_count_d;
  logic                 error_q, error_d;
  logic [ERR_W-1:0]     err_code_q, err_code_d;

  logic [NUM_TILES-1:0] arrived_w, new_arr_c, rel_c, gathered_c;
  logic                 arm_en_c, complete_c, viol_c, tmo_fire_c, err_set_c;
  logic [ERR_W-1:0]     err_new_c;

`ifdef SYNC_BARRIER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_hit_c;

  // Counts cycles spent in COLLECT; zero everywhere else so each entry starts fresh.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_COLLECT) tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    tmo_hit_c = (cfg_timeout != '0) && (tmo_cnt_q == cfg_timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Arrivals are blocked during the release cycle so the next barrier starts from IDLE.
  assign arm_en_c = (state_q != ST_RELEASE);

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
    sync_arrival_tracker u_trk (
      .clk           (clk),
      .rst           (rst),
      .request       (sync_request[i]),
      .mask          (mask_q[i]),
      .arm_en        (arm_en_c),
      .rel           (rel_c[i]),
      .arrived       (arrived_w[i]),
      .new_arrival_c (new_arr_c[i])
    );
  end

  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    pend_d          = pend_q;
    pend_v_d        = pend_v_q;
    sync_grant_d    = '0;
    global_sync_d   = 1'b0;
    barrier_count_d = barrier_count_q;
    rel_c           = '0;
    tmo_fire_c      = 1'b0;

    gathered_c = arrived_w | new_arr_c;
    complete_c = (mask_q != '0) && (gathered_c == mask_q);
    viol_c     = |(sync_request & ~mask_q);

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (complete_c) begin
          state_d         = ST_RELEASE;
          sync_grant_d    = gathered_c;
          rel_c           = gathered_c;
          global_sync_d   = 1'b1;
          barrier_count_d = barrier_count_q + CNT_W'(1);
        end else if ((state_q == ST_IDLE) && (new_arr_c != '0)) begin
          state_d = ST_COLLECT;
`ifdef SYNC_BARRIER_TIMEOUT_EN
        end else if ((state_q == ST_COLLECT) && tmo_hit_c) begin
          state_d       = ST_RELEASE;
          sync_grant_d  = gathered_c;
          rel_c         = gathered_c;
          global_sync_d = 1'b1;
          tmo_fire_c    = 1'b1;
`endif
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Mask loads immediately only when no barrier is forming; otherwise it waits for IDLE.
    if (state_q == ST_RELEASE) begin
      if (cfg_mask_we)   mask_d = cfg_mask;
      else if (pend_v_q) mask_d = pend_q;
      pend_v_d = 1'b0;
    end else if (cfg_mask_we) begin
      if ((state_q == ST_IDLE) && (new_arr_c == '0)) begin
        mask_d = cfg_mask;
      end else begin
        pend_d   = cfg_mask;
        pend_v_d = 1'b1;
      end
    end

    busy_d     = (state_d != ST_IDLE);
    err_set_c  = viol_c | tmo_fire_c;
    err_new_c  = tmo_fire_c ? ERR_TIMEOUT : ERR_NONMEMBER;
    error_d    = err_set_c ? 1'b1 : (err_clr ? 1'b0 : error_q);
    err_code_d = err_code_next(err_code_q, err_set_c, err_clr, err_new_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mask_q          <= '0;
      pend_q          <= '0;
      pend_v_q        <= 1'b0;
      sync_grant_q    <= '0;
      global_sync_q   <= 1'b0;
      busy_q          <= 1'b0;
      barrier_count_q <= '0;
      error_q         <= 1'b0;
      err_code_q      <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      pend_q          <= pend_d;
      pend_v_q        <= pend_v_d;
      sync_grant_q    <= sync_grant_d;
      global_sync_q   <= global_sync_d;
      busy_q          <= busy_d;
      barrier_count_q <= barrier_count_d;
      error_q         <= error_d;
      err_code_q      <= err_code_d;
    end
  end

  assign sync_grant    = sync_grant_q;
  assign global_sync   = global_sync_q;
  assign arrived       = arrived_w;
  assign busy          = busy_q;
  assign barrier_count = barrier_count_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_sync_barrier_controller.sv
// Bench for sync_barrier_controller: directed barrier scenarios plus randomized tile traffic vs. a barrier model.
module tb_sync_barrier_controller;

  localparam int unsigned NT = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] cfg_mask;
  logic          cfg_mask_we;
  logic          err_clr;
  logic [NT-1:0] sync_request;
  logic [NT-1:0] sync_grant;
  logic          global_sync;
  logic [NT-1:0] arrived;
  logic          busy;
  logic [CW-1:0] barrier_count;
  logic          error;
  logic [1:0]    err_code;
`ifdef SYNC_BARRIER_TIMEOUT_EN
  logic [15:0]   cfg_timeout;
`endif

  always #5 clk = ~clk;

  sync_barrier_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mask      (cfg_mask),
    .cfg_mask_we   (cfg_mask_we),
`ifdef SYNC_BARRIER_TIMEOUT_EN
    .cfg_timeout   (cfg_timeout),
`endif
    .err_clr       (err_clr),
    .sync_request  (sync_request),
    .sync_grant    (sync_grant),
    .global_sync   (global_sync),
    .arrived       (arrived),
    .busy          (busy),
    .barrier_count (barrier_count),
    .error         (error),
    .err_code      (err_code)
  );

  int checks   = 0;
  int failures = 0;

  // Barrier model: phase is derived from which tiles have arrived and whether a release is in flight.
  bit [NT-1:0] m_mask, m_pend, m_armed, m_arr, e_grant;
  bit          m_pend_v, m_rel, e_gs, m_err;
  bit [CW-1:0] m_count;
  int          m_code;
  int          m_tcnt;

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_pend_v = 1'b0; m_armed = '1; m_arr = '0;
    m_rel = 1'b0; e_grant = '0; e_gs = 1'b0; m_count = '0; m_err = 1'b0;
    m_code = 0; m_tcnt = 0;
  endtask

  task automatic model_step();
    bit [NT-1:0] newa, all;
    bit          was_rel, collecting, fire, tfire, viol, set;
    int          code_new;
    if (rst) begin
      model_reset();
      return;
    end
    was_rel    = m_rel;
    collecting = !m_rel && (m_arr != '0);
    newa       = was_rel ? '0 : (sync_request & m_armed & m_mask & ~m_arr);
    all        = m_arr | newa;
    fire       = !was_rel && (m_mask != '0) && (all == m_mask);
    tfire      = 1'b0;
`ifdef SYNC_BARRIER_TIMEOUT_EN
    if (collecting && !fire && (cfg_timeout != 0) && (m_tcnt == int'(cfg_timeout))) tfire = 1'b1;
    m_tcnt = collecting ? (m_tcnt + 1) % 65536 : 0;
`endif
    viol = (sync_request & ~m_mask) != '0;
    if (was_rel) begin
      if (cfg_mask_we)   m_mask = cfg_mask;
      else if (m_pend_v) m_mask = m_pend;
      m_pend_v = 1'b0;
    end else if (cfg_mask_we) begin
      if (m_arr == '0 && newa == '0) m_mask = cfg_mask;
      else begin m_pend = cfg_mask; m_pend_v = 1'b1; end
    end
    e_gs    = fire || tfire;
    e_grant = e_gs ? all : '0;
    if (fire) m_count = m_count + 1'b1;
    for (int i = 0; i < NT; i++) begin
      if (e_gs && all[i])       m_armed[i] = 1'b0;
      else if (!sync_request[i]) m_armed[i] = 1'b1;
    end
    m_arr = e_gs ? '0 : all;
    m_rel = e_gs;
    set      = viol || tfire;
    code_new = tfire ? 2 : 1;
    if (set) begin
      m_err = 1'b1;
      if (err_clr || m_code == 0) m_code = code_new;
    end else if (err_clr) begin
      m_err = 1'b0; m_code = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare every output.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("sync_grant",    32'(sync_grant),    32'(e_grant));
    chk("global_sync",   32'(global_sync),   32'(e_gs));
    chk("arrived",       32'(arrived),       32'(m_arr));
    chk("busy",          32'(busy),          32'(m_rel || (m_arr != '0)));
    chk("barrier_count", 32'(barrier_count), 32'(m_count));
    chk("error",         32'(error),         32'(m_err));
    chk("err_code",      32'(err_code),      32'(m_code));
  endtask

  task automatic load_mask(input logic [NT-1:0] m);
    cfg_mask = m; cfg_mask_we = 1'b1;
    tick();
    cfg_mask_we = 1'b0;
  endtask

  bit [NT-1:0] granted;
  int          hold [NT];
  logic [NT-1:0] raise_at;

  initial begin
    rst = 1'b1; cfg_mask = '0; cfg_mask_we = 1'b0; err_clr = 1'b0; sync_request = '0;
`ifdef SYNC_BARRIER_TIMEOUT_EN
    cfg_timeout = '0;
`endif
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_grant", 32'(sync_grant), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_count", 32'(barrier_count), 32'h0);
    chk("reset_error", 32'(error), 32'h0);

    // Staggered arrivals at cycles 2,5,7,9 -> single grant visible at cycle 10.
    load_mask(4'b1111);
    for (int c = 0; c < 12; c++) begin
      sync_request[0] = (c >= 2);
      sync_request[1] = (c >= 5);
      sync_request[2] = (c >= 7);
      sync_request[3] = (c >= 9);
      tick();
      chk("stagger_grant", 32'(sync_grant), (c == 9) ? 32'hf : 32'h0);
    end
    chk("stagger_count", 32'(barrier_count), 32'd1);
    sync_request = '0; tick(); tick();
    sync_request = 4'b1111; tick();
    chk("together_grant", 32'(sync_grant), 32'hf);
    chk("together_count", 32'(barrier_count), 32'd2);
    tick(); tick(); tick();
    chk("held_no_regrant", 32'(barrier_count), 32'd2);
    sync_request = '0; tick();

    // Non-participant request flags an error; participants still release on their own.
    load_mask(4'b0101);
    sync_request = 4'b0010; tick();
    chk("nonmember_error", 32'(error), 32'h1);
    chk("nonmember_code",  32'(err_code), 32'h1);
    sync_request = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 32'(error), 32'h0);
    sync_request = 4'b0101; tick();
    chk("partial_mask_grant", 32'(sync_grant), 32'h5);
    sync_request = '0; tick();

    // Mask write during COLLECT is deferred to the next barrier.
    load_mask(4'b1111);
    sync_request = 4'b0011; tick();
    cfg_mask = 4'b0011; cfg_mask_we = 1'b1; tick(); cfg_mask_we = 1'b0;
    chk("deferred_busy", 32'(busy), 32'h1);
    sync_request = 4'b1111; tick();
    chk("deferred_old_mask", 32'(sync_grant), 32'hf);
    sync_request = '0; tick(); tick();
    sync_request = 4'b0011; tick();
    chk("deferred_new_mask", 32'(sync_grant), 32'h3);
    sync_request = '0; tick(); tick();

    // Reset mid-barrier drops the arrivals and issues no grant.
    load_mask(4'b1111);
    sync_request = 4'b0111; tick(); tick();
    chk("pre_rst_arrived", 32'(arrived), 32'h7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_arrived", 32'(arrived), 32'h0);
    chk("rst_grant",   32'(sync_grant), 32'h0);
    sync_request = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;

`ifdef SYNC_BARRIER_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      load_mask(4'b1111);
      cfg_timeout = 16'd20;
      sync_request = 4'b0001;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (global_sync) begin
          seen = 1'b1;
          chk("timeout_grant", 32'(sync_grant), 32'h1);
          chk("timeout_code",  32'(err_code), 32'h2);
          chk("timeout_count", 32'(barrier_count), 32'h0);
        end
      end
      chk("timeout_seen", 32'(seen), 32'h1);
      sync_request = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("timeout_clr", 32'(error), 32'h0);
      cfg_timeout = 16'($urandom_range(0, 30));
    end
`endif

    // Random tile traffic: participants hold until granted, then linger 0..3 cycles.
    granted = '0;
    for (int i = 0; i < NT; i++) hold[i] = 0;
    load_mask(4'b1111);
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 499) == 0);
      cfg_mask_we = ($urandom_range(0, 39) == 0);
      cfg_mask    = 4'($urandom);
      err_clr     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NT; i++) begin
        if (e_grant[i]) begin
          granted[i] = 1'b1;
          hold[i]    = $urandom_range(0, 3);
        end
        if (sync_request[i]) begin
          if (granted[i]) begin
            if (hold[i] == 0) begin sync_request[i] = 1'b0; granted[i] = 1'b0; end
            else hold[i]--;
          end else if (!m_mask[i] && $urandom_range(0, 3) == 0) begin
            sync_request[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          sync_request[i] = 1'b1;
        end
      end
      if (rst) granted = '0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
